lfsr_gen: RTL
=============

# lfsr_gen

Parametrised Fibonacci LFSR, the next generation of the fixed 4-bit LFSR. Width, feedback polynomial, reset seed and XOR/XNOR feedback sense are all configurable. Adds step enable, runtime seed load, lock-up detection with automatic recovery, and a wrap pulse at the end of each period. It serves as the shared pseudo-random source for test-pattern generators, scramblers and BIST stimulus in the design.

## Interface
- `WIDTH`, 8: register width, legal range 3..32.
- `TAPS`, 8'hB8: feedback mask, WIDTH bits.
  - Bit i set means `state[i]` enters the feedback reduction.
  - Bit WIDTH-1 must be set.
- `SEED`, 1: reset and recovery value, WIDTH bits. Must not equal LOCK.
- `XNOR`, 0: feedback sense. 0 = XOR, 1 = XNOR.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `en` input 1: advance one step this cycle.
- `load` input 1: load `seed_in` this cycle. Has priority over `en`.
- `seed_in` input WIDTH: value to load.
- `state` output WIDTH: current register contents.
- `out_bit` output 1: serial output, equal to `state[WIDTH-1]`.
- `wrap` output 1: one-cycle pulse when the register returns to the start value.
- `lock_err` output 1: one-cycle pulse when a lock-up value was intercepted.
- `step_cnt` output WIDTH: steps since the last load or wrap. Present only with `LFSR_GEN_CNT_EN`.

## Operation
- LOCK is the lock-up value: all-zeros when `XNOR`=0, all-ones when `XNOR`=1.
- Feedback: `fb` = reduction XOR of (`state` & `TAPS`), inverted when `XNOR`=1.
- Step: next `state` = {`state[WIDTH-2:0]`, `fb`}.
- Internal `start` register holds the reference value used for `wrap`. It is not a port.
- Priority each cycle: `load`, then `en`, then hold.
- `load`=1 and `seed_in` != LOCK:
  - `state` <= `seed_in`, `start` <= `seed_in`, counter cleared.
  - `en` is ignored that cycle.
- `load`=1 and `seed_in` == LOCK:
  - `state` <= SEED, `start` <= SEED, counter cleared.
  - `lock_err` pulses the next cycle.
- `en`=1, `load`=0:
  - `state` <= next.
  - If next == `start`: `wrap` pulses the next cycle (registered) and the counter clears.
  - Otherwise the counter increments, wrapping modulo 2^WIDTH.
- Safety net for SEU or X-corruption: if `state` == LOCK while `en`=1, `state` <= SEED and `lock_err` pulses. No `wrap` is produced in that case.
- `en`=0, `load`=0: all registers hold. `wrap` and `lock_err` deassert.
- With a maximal-length `TAPS`, the period is 2^WIDTH − 1 steps.
- No state machine beyond the shift register. `wrap` and `lock_err` are registered flags.

## Timing
- Reset values: `state` = SEED, `start` = SEED, `wrap` = 0, `lock_err` = 0, `step_cnt` = 0, `out_bit` = SEED[WIDTH-1].
- Reset assertion clears the registers immediately, with no clock required. Deassertion is synchronised externally.
- Reset mid-sequence: everything returns to the reset values, with no residual `wrap` or `lock_err`.
- Latency: `state` updates on the first rising edge after `en`/`load` is sampled. `wrap` and `lock_err` appear in the cycle where the new `state` is visible.
- `out_bit` is combinational from `state`, so it adds no extra latency.
- `load` and `en` asserted in the same cycle: load wins and no step occurs.
- `wrap` and `lock_err` never assert in the same cycle.

## Configuration
- `LFSR_GEN_CNT_EN` defined:
  - The `step_cnt` port and its WIDTH-bit counter are compiled in.
  - It counts accepted steps, clears on load, wrap and lock-up recovery, and reads 0 in the cycle `wrap` is high.
- `LFSR_GEN_CNT_EN` undefined:
  - The port and counter are absent.
  - All other behaviour is identical.

## Test plan
All scenarios use WIDTH=4, TAPS=4'b1100, SEED=4'b0001, XNOR=0 unless stated.
- Reset sequence: `rst` low, then high; `en`=1 for 15 cycles.
  - `state` = 1, 2, 4, 9, 3, 6, D, A, 5, B, 7, F, E, C, 8, then 1.
  - `wrap`=1 only with the return to 1; `step_cnt` reaches 14 then 0.
- Load, then run: `load`=1 with `seed_in`=4'h6, then `en`=1.
  - `state` = 6, D, A, …
  - `wrap` fires 15 steps later, on the return to 6.
- Lock-up load: `load`=1 with `seed_in`=0.
  - `state`=1 the next cycle, `lock_err`=1 for one cycle, `step_cnt`=0.
- Simultaneous controls: `load`=1, `en`=1, `seed_in`=4'hA.
  - `state`=A, not the step of the old value.
  - Next, `en` low for 3 cycles: `state` holds at A with no pulses.
- Asynchronous reset mid-run: drop `rst` between clock edges at `state`=7.
  - `state`=1 immediately, with flags low.
  - XNOR variant (XNOR=1, SEED=0): forcing LOCK=4'hF with `en`=1 gives `state`=0 and a `lock_err` pulse.

Source files
------------

// File: rtl/lfsr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : lfsr_gen                                                        |
// | Purpose  : Parametrised Fibonacci LFSR with seed load, lock-up recovery,   |
// |            period-wrap pulse and optional step counter (LFSR_GEN_CNT_EN).  |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module lfsr_gen #(
    parameter int              WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS = 8'hB8,
    parameter logic [WIDTH-1:0] SEED = {{(WIDTH-1){1'b0}}, 1'b1},
    parameter bit              XNOR  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic             out_bit,
    output logic             wrap,
    output logic             lock_err
`ifdef LFSR_GEN_CNT_EN
   ,output logic [WIDTH-1:0] step_cnt
`endif
);

    // Lock-up value: the one state the feedback can never leave.
    localparam logic [WIDTH-1:0] c_lock = XNOR ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_start;
    logic             r_wrap;
    logic             r_lock_err;

    logic             w_fb;
    logic [WIDTH-1:0] w_next;
    logic             w_seed_lock;
    logic             w_state_lock;
    logic             w_next_is_start;

    always_comb begin
        w_fb            = (^(r_state & TAPS)) ^ XNOR;
        w_next          = {r_state[WIDTH-2:0], w_fb};
        w_seed_lock     = (seed_in == c_lock);
        w_state_lock    = (r_state == c_lock);
        w_next_is_start = (w_next == r_start);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SEED;
            r_start    <= SEED;
            r_wrap     <= 1'b0;
            r_lock_err <= 1'b0;
        end else if (load) begin
            r_state    <= w_seed_lock ? SEED : seed_in;
            r_start    <= w_seed_lock ? SEED : seed_in;
            r_wrap     <= 1'b0;
            r_lock_err <= w_seed_lock;
        end else if (en) begin
            // A corrupted lock-up state is replaced by SEED instead of stepping.
            if (w_state_lock) begin
                r_state    <= SEED;
                r_wrap     <= 1'b0;
                r_lock_err <= 1'b1;
            end else begin
                r_state    <= w_next;
                r_wrap     <= w_next_is_start;
                r_lock_err <= 1'b0;
            end
        end else begin
            r_wrap     <= 1'b0;
            r_lock_err <= 1'b0;
        end
    end

    assign state    = r_state;
    assign out_bit  = r_state[WIDTH-1];
    assign wrap     = r_wrap;
    assign lock_err = r_lock_err;

`ifdef LFSR_GEN_CNT_EN
    logic [WIDTH-1:0] r_cnt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;

    always_comb begin
        w_cnt_clr = load | (en & (w_state_lock | w_next_is_start));
        w_cnt_inc = en & ~load;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (w_cnt_clr) begin
            r_cnt <= '0;
        end else if (w_cnt_inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign step_cnt = r_cnt;
`endif

endmodule
`default_nettype wire
